// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per clock, valid/ready on both sides.
// Optional build macro DIV_SELFCHECK_EN adds a q*d+r == dividend consistency check on chk_err.
module seq_restoring_divider #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_zero,
   output logic                  chk_err
);
   localparam int RW = DIVISOR_W + 1;
   localparam int CW = $clog2(DIVIDEND_W);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [RW-1:0]           r;
   logic [DIVIDEND_W-1:0]   q_sh;     // dividend bits shift out the top, quotient bits shift in the bottom
   logic [DIVISOR_W-1:0]    dvsr;

   logic [RW:0]             p;
   logic                    q_bit;
   logic [RW-1:0]           r_nxt;
   logic [DIVIDEND_W-1:0]   q_fin;
   logic                    last_iter;

   always_comb begin
      p     = {r, q_sh[DIVIDEND_W-1]};
      q_bit = (p >= {2'b00, dvsr});
      r_nxt = q_bit ? RW'(p - {2'b00, dvsr}) : RW'(p);
      q_fin = {q_sh[DIVIDEND_W-2:0], q_bit};
   end

   assign last_iter = (cnt == CW'(DIVIDEND_W-1));
   assign in_ready  = (state == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         r         <= '0;
         q_sh      <= '0;
         dvsr      <= '0;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               dvsr <= divisor;
               q_sh <= dividend;
               r    <= '0;
               cnt  <= '0;
               // Zero divisor skips iteration; result is parked and published one edge later
               if (divisor == '0) begin
                  quotient  <= '1;
                  remainder <= dividend[DIVISOR_W-1:0];
                  div_zero  <= 1'b1;
                  state     <= DONE;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               q_sh <= q_fin;
               r    <= r_nxt;
               cnt  <= cnt + 1'b1;
               if (last_iter) begin
                  quotient  <= q_fin;
                  remainder <= r_nxt[DIVISOR_W-1:0];
                  div_zero  <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DIV_SELFCHECK_EN
   localparam int PW = DIVIDEND_W + DIVISOR_W;

   logic [DIVIDEND_W-1:0] dvnd;
   logic                  chk_nxt;

   always_comb
      chk_nxt = ((PW'(q_fin) * PW'(dvsr) + PW'(r_nxt[DIVISOR_W-1:0])) != PW'(dvnd)) ||
                (r_nxt[DIVISOR_W-1:0] >= dvsr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvnd    <= '0;
         chk_err <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         dvnd    <= dividend;
         chk_err <= 1'b0;
      end else if (state == CALC && last_iter) begin
         chk_err <= chk_nxt;
      end
   end
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider: latency, results, div-by-zero, backpressure, reset.
module tb_seq_restoring_divider;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_zero;
   logic        chk_err;

   int checks = 0;
   int errors = 0;

   seq_restoring_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .div_zero(div_zero), .chk_err(chk_err)
   );

   always #5 clk = ~clk;

   // Drives one accept edge, then counts edges until out_valid (bounded at 40).
   task automatic issue(input logic [15:0] a, input logic [7:0] b, output int lat);
      in_valid = 1'b1; dividend = a; divisor = b;
      @(posedge clk); #1;
      in_valid = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if ({quotient, remainder, div_zero, chk_err} !== 26'd0) begin errors++;
         $display("FAIL reset_outputs got q=%h r=%h dz=%b ce=%b want all 0", quotient, remainder, div_zero, chk_err); end
   endtask

   task automatic test_basic();
      int lat;
      issue(16'd1000, 8'd7, lat);
      checks++; if (lat != 16) begin errors++; $display("FAIL basic_latency got %0d want 16", lat); end
      checks++; if (quotient !== 16'd142 || remainder !== 8'd6) begin errors++;
         $display("FAIL basic_1000_7 got q=%0d r=%0d want q=142 r=6", quotient, remainder); end
      checks++; if (div_zero !== 1'b0 || chk_err !== 1'b0) begin errors++;
         $display("FAIL basic_flags got dz=%b ce=%b want 0 0", div_zero, chk_err); end
      consume();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
         $display("FAIL basic_consume got ov=%b ir=%b want 0 1", out_valid, in_ready); end
   endtask

   task automatic test_extremes();
      int lat;
      issue(16'd65535, 8'd255, lat);
      checks++; if (lat != 16 || quotient !== 16'd257 || remainder !== 8'd0 || chk_err !== 1'b0) begin errors++;
         $display("FAIL ext_65535_255 got lat=%0d q=%0d r=%0d ce=%b want 16 257 0 0", lat, quotient, remainder, chk_err); end
      consume();
      issue(16'd65535, 8'd1, lat);
      checks++; if (lat != 16 || quotient !== 16'd65535 || remainder !== 8'd0 || div_zero !== 1'b0) begin errors++;
         $display("FAIL ext_65535_1 got lat=%0d q=%0d r=%0d dz=%b want 16 65535 0 0", lat, quotient, remainder, div_zero); end
      consume();
   endtask

   task automatic test_small();
      int lat;
      issue(16'd5, 8'd200, lat);
      checks++; if (lat != 16 || quotient !== 16'd0 || remainder !== 8'd5 || chk_err !== 1'b0) begin errors++;
         $display("FAIL small_5_200 got lat=%0d q=%0d r=%0d ce=%b want 16 0 5 0", lat, quotient, remainder, chk_err); end
      consume();
      issue(16'd0, 8'd9, lat);
      checks++; if (lat != 16 || quotient !== 16'd0 || remainder !== 8'd0) begin errors++;
         $display("FAIL small_0_9 got lat=%0d q=%0d r=%0d want 16 0 0", lat, quotient, remainder); end
      consume();
   endtask

   task automatic test_div_zero();
      int lat;
      issue(16'd1234, 8'd0, lat);
      checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
      checks++; if (quotient !== 16'hFFFF || remainder !== 8'hD2 || div_zero !== 1'b1 || chk_err !== 1'b0) begin errors++;
         $display("FAIL dz_result got q=%h r=%h dz=%b ce=%b want ffff d2 1 0", quotient, remainder, div_zero, chk_err); end
      consume();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dz_consume in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_backpressure();
      int lat;
      int bad = 0;
      issue(16'd1000, 8'd7, lat);
      checks++; if (lat != 16) begin errors++; $display("FAIL bp_latency got %0d want 16", lat); end
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0); dividend = 16'(100 + i); divisor = 8'(3 + i);
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd142 || remainder !== 8'd6 ||
             div_zero !== 1'b0 || chk_err !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cycle %0d got ov=%b ir=%b q=%0d r=%0d dz=%b ce=%b want 1 0 142 6 0 0",
                     i, out_valid, in_ready, quotient, remainder, div_zero, chk_err);
         end
      end
      checks++; if (bad != 0) errors++;
      in_valid = 1'b0;
      consume();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
         $display("FAIL bp_release got ir=%b ov=%b want 1 0", in_ready, out_valid); end
   endtask

   task automatic test_reset_mid();
      int lat;
      in_valid = 1'b1; dividend = 16'd300; divisor = 8'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
         $display("FAIL rstmid_ctrl got ov=%b ir=%b want 0 1", out_valid, in_ready); end
      checks++; if ({quotient, remainder, div_zero, chk_err} !== 26'd0) begin errors++;
         $display("FAIL rstmid_outputs got q=%h r=%h dz=%b ce=%b want all 0", quotient, remainder, div_zero, chk_err); end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      issue(16'd300, 8'd3, lat);
      checks++; if (lat != 16 || quotient !== 16'd100 || remainder !== 8'd0 || chk_err !== 1'b0) begin errors++;
         $display("FAIL rstmid_300_3 got lat=%0d q=%0d r=%0d ce=%b want 16 100 0 0", lat, quotient, remainder, chk_err); end
      consume();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_small();
      test_div_zero();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
